// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
// Holds the FSM state enum, quarter-bit phase enum and frame timing constants.
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;

    localparam int TICKS_START   = 4;
    localparam int TICKS_STOP    = 4;
    localparam int TICKS_GAP     = 4;
    localparam int BITS_PER_BYTE = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_tick.sv
// Quarter-bit tick generator: one-cycle o_tick every CLK_DIV enabled cycles.
// Ports: i_clk, i_rst_n (sync), i_en, i_clr (sync clear), o_tick, o_phase (Q0..Q3).
module i2c_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    output logic       o_tick,
    output logic [1:0] o_phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ph_q, ph_d;

    assign o_tick  = i_en && (cnt_q == CW'(CLK_DIV - 1));
    assign o_phase = ph_q;

    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (i_clr) begin
            cnt_d = '0;
            ph_d  = '0;
        end else if (i_en) begin
            if (o_tick) begin
                cnt_d = '0;
                ph_d  = ph_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            ph_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Write-only I2C configuration master walking an external ROM table with ACK checking and retry.
// Ports: clock/reset, i_start, ROM address/data, SCL/SDA pad signals, busy/finished/error status.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         N_REGS     = 11,
    parameter int         DATA_BYTES = 2,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         CLK_DIV    = 2,
    parameter int         MAX_RETRY  = 3,
    parameter int         ACK_CHECK  = 1,
    localparam int        IW         = idx_width(N_REGS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    output logic [IW-1:0]           o_rom_addr,
    input  logic [8*DATA_BYTES-1:0] i_rom_data,
    input  logic                    i_sda,
    output logic                    o_scl,
    output logic                    o_sda,
    output logic                    o_sda_oen,
    output logic                    o_busy,
    output logic                    o_finished,
    output logic                    o_error,
    output logic [IW-1:0]           o_nack_idx,
    output logic [2:0]              o_retry_cnt
);

    localparam int SW = 8 * (DATA_BYTES + 1);

    state_e          st_q, st_d;
    logic            ld_q, ld_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [2:0]      tcnt_q, tcnt_d;
    logic            nack_q, nack_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   nidx_q, nidx_d;
    logic [2:0]      retry_q, retry_d;
    logic            scl_q, scl_d, sda_q, sda_d, oen_q, oen_d;
    logic            busy_q, busy_d, fin_q, fin_d, err_q, err_d;

    logic            tick, tg_en, end_bit, scl_hi;
    logic [1:0]      phase_raw;
    phase_e          ph;

    // The divider only runs during bus activity; LOAD holds it cleared so
    // every frame starts exactly at Q0.
    assign tg_en = (st_q == S_START) || (st_q == S_BIT) || (st_q == S_ACK) ||
                   (st_q == S_STOP) || (st_q == S_GAP);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (tg_en),
        .i_clr   (!tg_en),
        .o_tick  (tick),
        .o_phase (phase_raw)
    );

    assign ph      = phase_e'(phase_raw);
    assign end_bit = tick && (ph == Q3);
    assign scl_hi  = (ph == Q2) || (ph == Q3);

    always_comb begin
        st_d    = st_q;
        ld_d    = ld_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tcnt_d  = tcnt_q;
        nack_d  = nack_q;
        idx_d   = idx_q;
        nidx_d  = nidx_q;
        retry_d = retry_q;
        unique case (st_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    st_d    = S_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                    ld_d    = 1'b0;
                end
            end
            S_LOAD: begin
                ld_d = 1'b1;
                // Second LOAD cycle: ROM data for idx_q is now valid.
                if (ld_q) begin
                    ld_d   = 1'b0;
                    sr_d   = {DEV_ADDR, 1'b0, i_rom_data};
                    nack_d = 1'b0;
                    bit_d  = '0;
                    byte_d = '0;
                    tcnt_d = '0;
                    st_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 3'd1;
                    if (tcnt_q == 3'(TICKS_START - 1)) begin
                        tcnt_d = '0;
                        st_d   = S_BIT;
                    end
                end
            end
            S_BIT: begin
                if (end_bit) begin
                    sr_d  = {sr_q[SW-2:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
                        bit_d = '0;
                        st_d  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (tick && (ph == Q2) && (ACK_CHECK != 0) && i_sda) begin
                    nack_d = 1'b1;
                end
                if (end_bit) begin
                    if (nack_q || (byte_q == 3'(DATA_BYTES))) begin
                        st_d = S_STOP;
                    end else begin
                        byte_d = byte_q + 3'd1;
                        st_d   = S_BIT;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 3'd1;
                    if (tcnt_q == 3'(TICKS_STOP - 1)) begin
                        tcnt_d = '0;
                        st_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 3'd1;
                    if (tcnt_q == 3'(TICKS_GAP - 1)) begin
                        tcnt_d = '0;
                        if (nack_q) begin
                            nidx_d = idx_q;
                            if (retry_q < 3'(MAX_RETRY)) begin
                                retry_d = retry_q + 3'd1;
                                st_d    = S_LOAD;
                            end else begin
                                st_d = S_ERROR;
                            end
                        end else if (idx_q == IW'(N_REGS - 1)) begin
                            st_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = '0;
                            st_d    = S_LOAD;
                        end
                    end
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (st_d == S_LOAD) || (st_d == S_START) || (st_d == S_BIT) ||
                 (st_d == S_ACK) || (st_d == S_STOP) || (st_d == S_GAP);
        fin_d  = (st_d == S_DONE);
        err_d  = (st_d == S_ERROR);
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        oen_d  = 1'b1;
        unique case (st_q)
            S_START: begin
                scl_d = (ph != Q3);
                sda_d = (ph == Q0) || (ph == Q1);
            end
            S_BIT: begin
                scl_d = scl_hi;
                sda_d = sr_q[SW-1];
            end
            S_ACK: begin
                scl_d = scl_hi;
                oen_d = 1'b0;
            end
            S_STOP: begin
                scl_d = scl_hi;
                sda_d = (ph == Q3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            st_q    <= S_IDLE;
            ld_q    <= 1'b0;
            sr_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tcnt_q  <= '0;
            nack_q  <= 1'b0;
            idx_q   <= '0;
            nidx_q  <= '0;
            retry_q <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            oen_q   <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            ld_q    <= ld_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tcnt_q  <= tcnt_d;
            nack_q  <= nack_d;
            idx_q   <= idx_d;
            nidx_q  <= nidx_d;
            retry_q <= retry_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            oen_q   <= oen_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    assign o_rom_addr  = idx_q;
    assign o_nack_idx  = nidx_q;
    assign o_retry_cnt = retry_q;
    assign o_scl       = scl_q;
    assign o_sda       = sda_q;
    assign o_sda_oen   = oen_q;
    assign o_busy      = busy_q;
    assign o_finished  = fin_q;
    assign o_error     = err_q;

endmodule
